// File: rtl/stack_pkg.sv
// stack_pkg: shared definitions for the search-path stack.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : sizing used by the search datapath
//   stackOp_e                     : per-cycle operation encoding, shared with
//                                   the search controller and the bench scoreboard
package stack_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 64;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_REPL = 2'd3
    } stackOp_e;

endpackage

// File: rtl/stack_mem.sv
// stack_mem: DEPTH x WIDTH register array, not reset.
//   clk           : write clock
//   we/waddr/wdata: synchronous write port
//   raddrA/rdataA : combinational read port (top refill)
//   raddrB/rdataB : combinational read port (peek)
// Reads of addresses at or beyond DEPTH return 0, so a DEPTH that is not a
// power of two never indexes past the array.
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddrA,
    output logic [WIDTH-1:0] rdataA,
    input  logic [AW-1:0]    raddrB,
    output logic [WIDTH-1:0] rdataB
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdataA = (32'(raddrA) < DEPTH) ? mem[raddrA] : '0;
    assign rdataB = (32'(raddrB) < DEPTH) ? mem[raddrB] : '0;

endmodule

// File: rtl/param_stack.sv
// param_stack: parametrised LIFO for path locations.
//   clk, rst (async, active-high), clr (sync clear)
//   push/pop/din : stack operations; push+pop replaces the top entry
//   err_clr      : sync clear of sticky overflow/underflow
//   top          : registered top-of-stack, 0 when empty
//   count/empty/full : occupancy
//   overflow/underflow : sticky error flags
//   pk_idx/pk_data/pk_valid : combinational peek, depth measured from the top
module param_stack
    import stack_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             err_clr,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    input  logic [IW-1:0]    pk_idx,
    output logic [WIDTH-1:0] pk_data,
    output logic             pk_valid
);

    stackOp_e         op;
    logic             wrEn;
    logic [IW-1:0]    wrAddr;
    logic [IW-1:0]    refillAddr;
    logic [WIDTH-1:0] refillData;
    logic [IW-1:0]    pkAddr;
    logic [WIDTH-1:0] pkRaw;
    logic             ovfSet;
    logic             unfSet;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // push+pop on an empty stack has nothing to replace, so it degrades to a push
    always_comb begin
        op = OP_NONE;
        case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = empty ? OP_PUSH : OP_REPL;
            default: op = OP_NONE;
        endcase
    end

    // rst/clr gate the write so an overridden push never lands in the array
    always_comb begin
        wrEn   = 1'b0;
        wrAddr = IW'(count);
        if (!rst && !clr) begin
            if (op == OP_PUSH && !full) begin
                wrEn   = 1'b1;
                wrAddr = IW'(count);
            end else if (op == OP_REPL) begin
                wrEn   = 1'b1;
                wrAddr = IW'(count - CW'(1));
            end
        end
    end

    assign ovfSet = (op == OP_PUSH) && full;
    assign unfSet = (op == OP_POP) && empty;

    // entry below the current top; only consumed when count >= 2
    assign refillAddr = IW'(count - CW'(2));

    assign pk_valid = (CW'(pk_idx) < count);
    assign pkAddr   = IW'(count - CW'(1) - CW'(pk_idx));
    assign pk_data  = pk_valid ? pkRaw : '0;

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (IW)
    ) uMem (
        .clk    (clk),
        .we     (wrEn),
        .waddr  (wrAddr),
        .wdata  (din),
        .raddrA (refillAddr),
        .rdataA (refillData),
        .raddrB (pkAddr),
        .rdataB (pkRaw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            top       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            count     <= '0;
            top       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (op)
                OP_PUSH: begin
                    if (!full) begin
                        count <= count + CW'(1);
                        top   <= din;
                    end
                end
                OP_POP: begin
                    if (count >= CW'(2)) begin
                        count <= count - CW'(1);
                        top   <= refillData;
                    end else if (count == CW'(1)) begin
                        count <= '0;
                        top   <= '0;
                    end
                end
                OP_REPL: top <= din;
                default: ;
            endcase
            // a new error on the same edge as err_clr leaves the flag set
            overflow  <= ovfSet | (overflow  & ~err_clr);
            underflow <= unfSet | (underflow & ~err_clr);
        end
    end

endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             err_clr;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
    logic [IW-1:0]    pk_idx;
    logic [WIDTH-1:0] pk_data;
    logic             pk_valid;

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .err_clr   (err_clr),
        .top       (top),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .pk_idx    (pk_idx),
        .pk_data   (pk_data),
        .pk_valid  (pk_valid)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // reference model: a plain queue, back() is the top of stack
    logic [WIDTH-1:0] mq[$];
    bit               mOvf;
    bit               mUnf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mOvf = 1'b0;
        mUnf = 1'b0;
    endtask

    task automatic modelOp(input bit c, input bit pu, input bit po,
                           input logic [WIDTH-1:0] d, input bit ec);
        bit ov = 1'b0;
        bit un = 1'b0;
        if (c) begin
            modelReset();
            return;
        end
        if (pu && po) begin
            if (mq.size() == 0) mq.push_back(d);
            else mq[mq.size()-1] = d;
        end else if (pu) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else ov = 1'b1;
        end else if (po) begin
            if (mq.size() > 0) void'(mq.pop_back());
            else un = 1'b1;
        end
        mOvf = ov | (mOvf & ~ec);
        mUnf = un | (mUnf & ~ec);
    endtask

    // compare every output against the model, sweeping the peek index
    task automatic checkAll(input string tag);
        int n = mq.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"},  32'(full),  32'(n == DEPTH));
        chk({tag, ".top"},   32'(top),   (n > 0) ? 32'(mq[n-1]) : 32'd0);
        chk({tag, ".ovf"},   32'(overflow),  32'(mOvf));
        chk({tag, ".unf"},   32'(underflow), 32'(mUnf));
        for (int i = 0; i < DEPTH; i++) begin
            pk_idx = IW'(i);
            #1;
            chk($sformatf("%s.pkv%0d", tag, i), 32'(pk_valid), 32'(i < n));
            chk($sformatf("%s.pkd%0d", tag, i), 32'(pk_data),
                (i < n) ? 32'(mq[n-1-i]) : 32'd0);
        end
    endtask

    // drive one cycle's inputs, clock it, update the model, check
    task automatic doOp(input string tag, input bit c, input bit pu, input bit po,
                        input logic [WIDTH-1:0] d, input bit ec);
        clr = c; push = pu; pop = po; din = d; err_clr = ec;
        @(posedge clk);
        modelOp(c, pu, po, d, ec);
        #1;
        checkAll(tag);
    endtask

    task automatic peekChk(input string tag, input int idx, input logic [WIDTH-1:0] exp);
        pk_idx = IW'(idx);
        #1;
        chk(tag, 32'(pk_data), 32'(exp));
    endtask

    initial begin
        logic [WIDTH-1:0] tops [4];
        logic [WIDTH-1:0] vals [5];
        tops = '{8'h33, 8'h22, 8'h11, 8'h00};
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        rst = 1'b1; clr = 1'b0; push = 1'b0; pop = 1'b0; din = '0; err_clr = 1'b0;
        pk_idx = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // reset then idle
        doOp("idle", 0, 0, 0, 8'h00, 0);
        chk("rst.count", 32'(count), 0);
        chk("rst.empty", 32'(empty), 1);
        pk_idx = '0; #1;
        chk("rst.pkv0", 32'(pk_valid), 0);

        // fill, then overflow
        for (int i = 0; i < 4; i++) doOp($sformatf("fill%0d", i), 0, 1, 0, vals[i], 0);
        chk("fill.full", 32'(full), 1);
        chk("fill.top", 32'(top), 32'h44);
        doOp("ovf", 0, 1, 0, vals[4], 0);
        chk("ovf.flag", 32'(overflow), 1);
        chk("ovf.top", 32'(top), 32'h44);
        peekChk("ovf.pk3", 3, 8'h11);

        // drain, then underflow, then clear the errors
        for (int i = 0; i < 4; i++) begin
            doOp($sformatf("drain%0d", i), 0, 0, 1, 8'h00, 0);
            chk($sformatf("drain%0d.top", i), 32'(top), 32'(tops[i]));
        end
        chk("drain.empty", 32'(empty), 1);
        doOp("unf", 0, 0, 1, 8'h00, 0);
        chk("unf.flag", 32'(underflow), 1);
        chk("unf.count", 32'(count), 0);
        doOp("errclr", 0, 0, 0, 8'h00, 1);
        chk("errclr.ovf", 32'(overflow), 0);
        chk("errclr.unf", 32'(underflow), 0);

        // replace-top
        doOp("r.p0", 0, 1, 0, 8'h11, 0);
        doOp("r.p1", 0, 1, 0, 8'h22, 0);
        doOp("repl", 0, 1, 1, 8'hAA, 0);
        chk("repl.count", 32'(count), 2);
        chk("repl.top", 32'(top), 32'hAA);
        peekChk("repl.pk1", 1, 8'h11);
        doOp("r.d0", 0, 0, 1, 8'h00, 0);
        doOp("r.d1", 0, 0, 1, 8'h00, 0);
        doOp("repl0", 0, 1, 1, 8'h5C, 0);
        chk("repl0.count", 32'(count), 1);
        chk("repl0.top", 32'(top), 32'h5C);
        chk("repl0.unf", 32'(underflow), 0);

        // replace-top while full sets no flag
        for (int i = 0; i < 3; i++) doOp("f.p", 0, 1, 0, 8'(8'h60 + i), 0);
        doOp("replFull", 0, 1, 1, 8'hE7, 0);
        chk("replFull.ovf", 32'(overflow), 0);
        chk("replFull.top", 32'(top), 32'hE7);

        // clear beats a concurrent push
        doOp("c.d", 0, 0, 1, 8'h00, 0);
        doOp("clr", 1, 1, 0, 8'h77, 0);
        chk("clr.count", 32'(count), 0);
        chk("clr.top", 32'(top), 0);

        // error set wins over err_clr on the same edge
        doOp("unfSet", 0, 0, 1, 8'h00, 1);
        chk("unfSet.flag", 32'(underflow), 1);

        // asynchronous reset in the middle of a push burst
        doOp("b0", 0, 1, 0, 8'hA1, 0);
        doOp("b1", 0, 1, 0, 8'hA2, 0);
        clr = 0; push = 1; pop = 0; din = 8'h99; err_clr = 0;
        @(posedge clk);
        modelOp(0, 1, 0, 8'h99, 0);
        #3 rst = 1'b1;
        #1;
        modelReset();
        chk("arst.count", 32'(count), 0);
        chk("arst.top", 32'(top), 0);
        chk("arst.empty", 32'(empty), 1);
        checkAll("arst");
        @(posedge clk);
        #2 rst = 1'b0;
        checkAll("arstHold");
        doOp("postRst", 0, 1, 0, 8'h01, 0);
        chk("postRst.count", 32'(count), 1);
        chk("postRst.top", 32'(top), 32'h01);

        // randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            bit c  = ($urandom_range(0, 39) == 0);
            bit pu = ($urandom_range(0, 99) < 55);
            bit po = ($urandom_range(0, 99) < 45);
            bit ec = ($urandom_range(0, 9) == 0);
            doOp($sformatf("rnd%0d", i), c, pu, po, 8'($urandom), ec);
        end

        clr = 0; push = 0; pop = 0; err_clr = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
